instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter: FIFO_DEPTH, 2, prefetch buffer entries (power of two, >=2).
REQ-002 Parameter: RET_W, 8, width of retired-instruction counter.
REQ-003 Clocking and reset are one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 clear  input  1  synchronous flush request from control unit.
REQ-007 run  input  1  permits starting new instructions.
REQ-008 in_valid  input  1  upstream instruction word valid.
REQ-009 in_data  input  16  upstream instruction word.
REQ-010 in_ready  output  1  sequencer can accept in_data this cycle.
REQ-011 counter  output  2  step index 0..3 fed to control unit.
REQ-012 inn  output  16  current instruction, stable for all four steps.
REQ-013 busy  output  1  state==EXEC.
REQ-014 done  output  1  combinational, high while EXEC and counter==3.
REQ-015 retired  output  RET_W  count of completed instructions.

Function
REQ-016 Transfer occurs on a clk edge where in_valid && in_ready; only then is in_data pushed into the FIFO.
REQ-017 in_ready = reset_n && !clear && (fifo_count < FIFO_DEPTH), using registered fifo_count; no push when full, even if a pop occurs in the same cycle.
REQ-018 States: IDLE, EXEC.
REQ-019 IDLE: counter holds 0, inn holds last value; at edge with fifo non-empty && run: inn <= FIFO head, pop, counter <= 0, -> EXEC.
REQ-020 EXEC, counter 0..2: counter increments by 1 per edge; inn unchanged; run ignored.
REQ-021 EXEC, counter==3: retired increments (wraps modulo 2^RET_W); if fifo non-empty && run: inn <= head, pop, counter <= 0, stay EXEC (back-to-back, no bubble); else counter <= 0, -> IDLE.
REQ-022 Deasserting run never aborts an instruction in flight; it only blocks the next start.
REQ-023 Simultaneous push and pop with fifo non-full: both occur, fifo_count unchanged.
REQ-024 Push into empty FIFO while IDLE and run: accepted at edge k, EXEC with counter 0 after edge k+1, done high after edge k+4.
REQ-025 clear (highest priority after reset): at edge, state <= IDLE, counter <= 0, FIFO flushed (count 0, pointers 0), inn <= 0; retired unchanged; push in same cycle is blocked by in_ready.
REQ-026 FIFO pointers wrap at FIFO_DEPTH; order is strictly first-in first-out.

Reset
REQ-027 While reset_n low: state IDLE, counter 0, inn 0, retired 0, FIFO empty, busy 0, done 0, in_ready 0.
REQ-028 Reset asserted mid-instruction discards the instruction and FIFO contents immediately; retired does not increment.
REQ-029 First push accepted at the first rising edge after reset_n release.

Structure
REQ-030 Package instr_seq_pkg holds state enum (IDLE, EXEC), STEP_LAST=2'd3, WORD_W=16.
REQ-031 One sub-module, instr_fifo (parameter FIFO_DEPTH, WORD_W; push/pop/flush, count, head), instantiated once; sequencing FSM resides in instr_sequencer.

Verification
REQ-032 Reset release, run=1, push 16'h0048 once -> counter 0,1,2,3 over edges k+1..k+4, inn=16'h0048 throughout, done one cycle, retired=1, then IDLE.
REQ-033 Push 16'h0001,16'h0002,16'h0003 back-to-back, run=1 -> in_ready low when count=2, instructions execute in order with no bubble, retired=3 after 12 EXEC cycles.
REQ-034 run=0 with two words queued -> busy stays 0, counter 0; raise run -> execution starts next edge.
REQ-035 Drop run at counter==1 of an instruction with one queued -> current completes (done pulses), then IDLE, queued word remains (in_ready reflects count=1).
REQ-036 clear at counter==2 with FIFO full -> next edge: IDLE, counter 0, inn 0, FIFO empty, in_ready 1 after clear drops, retired unchanged.
REQ-037 reset_n low at counter==1 -> all outputs 0 asynchronously; 256 completed instructions -> retired wraps to 0.

Source files
------------

// File: rtl/instr_seq_pkg.sv
// Shared types and constants for the instruction sequencer and its prefetch FIFO.
package instr_seq_pkg;
   localparam int         WORD_W    = 16;
   localparam logic [1:0] STEP_LAST = 2'd3;

   typedef enum logic {IDLE, EXEC} state_e;
endpackage

// File: rtl/instr_fifo.sv
// Prefetch FIFO for instruction words; flush has priority over push and pop.
module instr_fifo #(
   parameter int FIFO_DEPTH = 2,
   parameter int WORD_W     = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          flush,
   input  logic                          push,
   input  logic [WORD_W-1:0]             wdata,
   input  logic                          pop,
   output logic [WORD_W-1:0]             head,
   output logic [$clog2(FIFO_DEPTH):0]   count
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   // Depth is a power of two, so pointers wrap by plain overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= wdata;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
endmodule

// File: rtl/instr_sequencer.sv
// Four-step instruction sequencer: pulls words from a prefetch FIFO and steps
// the control unit through counter 0..3 per instruction, back-to-back when possible.
module instr_sequencer
   import instr_seq_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int RET_W      = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              run,
   input  logic              in_valid,
   input  logic [15:0]       in_data,
   output logic              in_ready,
   output logic [1:0]        counter,
   output logic [15:0]       inn,
   output logic              busy,
   output logic              done,
   output logic [RET_W-1:0]  retired
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   state_e             state_q, state_d;
   logic [1:0]         counter_q, counter_d;
   logic [WORD_W-1:0]  inn_q, inn_d;
   logic [RET_W-1:0]   retired_q, retired_d;
   logic [CNT_W-1:0]   fifo_count;
   logic [WORD_W-1:0]  fifo_head;
   logic               push, pop, start_ok;

   // Readiness uses only registered occupancy, so a same-cycle pop never frees a slot.
   assign in_ready = reset_n && !clear && (fifo_count < CNT_W'(FIFO_DEPTH));
   assign push     = in_valid && in_ready;
   assign start_ok = (fifo_count != '0) && run;

   instr_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .WORD_W(WORD_W)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (clear),
      .push    (push),
      .wdata   (in_data),
      .pop     (pop),
      .head    (fifo_head),
      .count   (fifo_count)
   );

   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      inn_d     = inn_q;
      retired_d = retired_q;
      pop       = 1'b0;
      if (clear) begin
         state_d   = IDLE;
         counter_d = 2'd0;
         inn_d     = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_ok) begin
                  inn_d     = fifo_head;
                  pop       = 1'b1;
                  counter_d = 2'd0;
                  state_d   = EXEC;
               end
            end
            EXEC: begin
               if (counter_q != STEP_LAST) begin
                  counter_d = counter_q + 2'd1;
               end else begin
                  retired_d = retired_q + RET_W'(1);
                  counter_d = 2'd0;
                  // Next word starts without a bubble if one is waiting.
                  if (start_ok) begin
                     inn_d = fifo_head;
                     pop   = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         counter_q <= 2'd0;
         inn_q     <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         inn_q     <= inn_d;
         retired_q <= retired_d;
      end
   end

   assign counter = counter_q;
   assign inn     = inn_q;
   assign busy    = (state_q == EXEC);
   assign done    = (state_q == EXEC) && (counter_q == STEP_LAST);
   assign retired = retired_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a scoreboard of accepted words checked at each start.
module tb_instr_sequencer;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        clear = 1'b0;
   logic        run = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_ready;
   logic [1:0]  counter;
   logic [15:0] inn;
   logic        busy;
   logic        done;
   logic [7:0]  retired;

   int          checks = 0;
   int          errors = 0;
   int          busy_cnt = 0;
   logic [15:0] exp_q[$];
   logic [15:0] sb_exp;

   instr_sequencer #(.FIFO_DEPTH(2), .RET_W(8)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear),
      .run      (run),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .counter  (counter),
      .inn      (inn),
      .busy     (busy),
      .done     (done),
      .retired  (retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [15:0] w);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = w;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $error("FAIL push_timeout: observed in_ready 0 expected 1 for word %0h", w);
      end else begin
         exp_q.push_back(w);
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      step();
      while (busy && n < 200) begin
         step();
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $error("FAIL idle_timeout: observed busy 1 expected 0");
      end
   endtask

   // Every instruction start must present the oldest accepted word.
   always @(negedge clk) begin
      if (busy === 1'b1) busy_cnt++;
      if (busy === 1'b1 && counter === 2'd0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL sb_empty: observed start of %0h expected no instruction", inn);
         end else begin
            sb_exp = exp_q.pop_front();
            assert (inn === sb_exp) else begin
               errors++;
               $error("FAIL sb_order: observed %0h expected %0h", inn, sb_exp);
            end
         end
      end
   end

   initial begin
      #12;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_counter", counter, 0);
      chk("rst_inn", inn, 0);
      chk("rst_retired", retired, 0);

      // Single instruction right after reset release.
      step();
      reset_n = 1'b1;
      run = 1'b1;
      #1;
      chk("rel_in_ready", in_ready, 1);
      push_word(16'h0048);
      chk("t1_not_started", busy, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t1_busy", busy, 1);
         chk("t1_counter", counter, i);
         chk("t1_inn", inn, 16'h0048);
         chk("t1_done", done, (i == 3));
      end
      step();
      chk("t1_idle", busy, 0);
      chk("t1_retired", retired, 1);
      chk("t1_inn_hold", inn, 16'h0048);
      chk("t1_done_low", done, 0);

      // Three words back-to-back; FIFO fills, no bubbles.
      busy_cnt = 0;
      push_word(16'h0001);
      push_word(16'h0002);
      push_word(16'h0003);
      chk("t2_full_ready", in_ready, 0);
      wait_idle();
      chk("t2_busy_cycles", busy_cnt, 12);
      chk("t2_retired", retired, 4);

      // Hold off with run low, then release.
      run = 1'b0;
      push_word(16'h0010);
      push_word(16'h0020);
      step();
      step();
      chk("t3_busy", busy, 0);
      chk("t3_counter", counter, 0);
      chk("t3_full_ready", in_ready, 0);
      run = 1'b1;
      step();
      chk("t3_start", busy, 1);
      chk("t3_inn", inn, 16'h0010);
      step();
      chk("t4_c1", counter, 1);
      run = 1'b0;
      step();
      step();
      chk("t4_done", done, 1);
      step();
      chk("t4_idle", busy, 0);
      chk("t4_retired", retired, 5);
      chk("t4_ready_cnt1", in_ready, 1);
      step();
      chk("t4_still_idle", busy, 0);

      // Clear mid-instruction with FIFO full.
      run = 1'b1;
      step();
      chk("t5_start", inn, 16'h0020);
      push_word(16'h0030);
      push_word(16'h0040);
      chk("t5_c2", counter, 2);
      chk("t5_full", in_ready, 0);
      clear = 1'b1;
      step();
      exp_q.delete();
      chk("t5_busy", busy, 0);
      chk("t5_counter", counter, 0);
      chk("t5_inn", inn, 0);
      chk("t5_retired", retired, 5);
      in_valid = 1'b1;
      in_data  = 16'h0099;
      #1;
      chk("t5_clear_blocks", in_ready, 0);
      step();
      clear = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("t5_ready_after", in_ready, 1);
      step();
      chk("t5_fifo_empty", busy, 0);

      // Asynchronous reset in flight.
      push_word(16'h0055);
      step();
      step();
      chk("t6_c1", counter, 1);
      reset_n = 1'b0;
      #1;
      exp_q.delete();
      chk("t6_busy", busy, 0);
      chk("t6_counter", counter, 0);
      chk("t6_inn", inn, 0);
      chk("t6_done", done, 0);
      chk("t6_retired", retired, 0);
      chk("t6_in_ready", in_ready, 0);
      step();
      reset_n = 1'b1;
      #1;
      chk("t6_rel_ready", in_ready, 1);

      // Retired counter wrap.
      for (int i = 0; i < 255; i++) push_word(16'(i + 16'h0100));
      wait_idle();
      chk("t7_ret255", retired, 255);
      push_word(16'hbeef);
      wait_idle();
      chk("t7_wrap", retired, 0);
      chk("t7_sb_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
